fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of the instruction word and of pc_4.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of entries (power of two, minimum 2).
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1 bit, discarding all queued entries (branch taken in MEM).
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the IF stage presents an entry.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the queue accepts the entry this cycle.
REQ-008 SHALL have ports in_pc_4 and in_instruction, input, WIDTH bits each, carrying the entry payload.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the head entry is presented to ID.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning ID consumes the head this cycle (not stalled).
REQ-011 SHALL have ports out_pc_4 and out_instruction, output, WIDTH bits each, carrying the head payload.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits, giving the current occupancy.

Function
REQ-013 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-014 SHALL drive in_ready = (count < DEPTH) || out_ready, so a push into a full queue is accepted while a pop occurs in the same cycle.
REQ-015 SHALL drive out_valid = (count != 0); out_pc_4 and out_instruction SHALL come from the head entry (registered storage), giving one-cycle push-to-pop latency.
REQ-016 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-017 SHALL wrap the read and write pointers from DEPTH-1 to 0.
REQ-018 SHALL, on flush, set count and both pointers to 0 at the next edge and ignore any push or pop in that cycle; flush SHALL take priority over push and pop.
REQ-019 SHALL drive in_ready = 0 during the flush cycle.
REQ-020 SHALL hold out payload stable while out_valid && !out_ready.
REQ-021 SHALL treat push while full without a pop as impossible by construction, because in_ready is low in that case.

Reset
REQ-022 SHALL, on reset, clear count, read pointer and write pointer to 0, so that out_valid=0 and in_ready=1 after the edge.
REQ-023 SHALL drive out_pc_4 and out_instruction to 0 after reset; storage contents are otherwise unreset.
REQ-024 SHALL give reset priority over flush, push and pop, including reset asserted mid-stream.

Configuration
REQ-025 SHALL, when macro FETCH_QUEUE_BYPASS_EN is defined, pass an incoming entry combinationally to the outputs when count == 0 and in_valid is high: out_valid=1, with the in_* payload on the outputs.
REQ-026 SHALL, in that bypass case, not store the entry if out_ready is high, and store it normally if out_ready is low.
REQ-027 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from in_* to out_*, with minimum latency of one cycle.

Structure
REQ-028 SHALL take the default WIDTH and the entry record typedef (pc_4 plus instruction) from shared package cpu_pkg.
REQ-029 SHALL keep the pointer/count logic in one sub-module, fifo_ctrl, parametrised by DEPTH, with payload storage in fetch_queue.

Verification
REQ-030 SHALL be verified by reset then push 0x20014000/pc_4 0x4, then 0x20014001/0x8, with out_ready=1, requiring them popped in order one cycle after each push (same cycle when FETCH_QUEUE_BYPASS_EN).
REQ-031 SHALL be verified by filling DEPTH=4 entries with out_ready=0, requiring count=4 and in_ready=0, and a fifth in_valid accepted only when out_ready=1.
REQ-032 SHALL be verified by pushing 6 entries with interleaved pops, requiring pointer wrap with out_instruction order 1..6 and no loss.
REQ-033 SHALL be verified by flush with count=3 and in_valid=1, requiring count=0 and out_valid=0 next cycle, with the flush-cycle entry dropped.
REQ-034 SHALL be verified by reset asserted with count=2 and simultaneous push/pop, requiring count=0, out_valid=0, in_ready=1 and outputs 0.
REQ-035 SHALL be verified by holding out_ready=0 for 5 cycles with the head at 0x8C020000, requiring the head payload stable throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: machine word width and the fetch entry record
// (pc_4 plus instruction) carried between IF and ID.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

    // Pointer width for a queue of the given depth; a depth of 1 still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Occupancy and pointer bookkeeping for a power-of-two circular queue.
// Payload storage lives in the instantiating module; this block only decides who moves.
module fifo_ctrl
    import cpu_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter bit  BYPASS = 1'b0,
    localparam int PTR_W  = ptr_width(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic             i_out_ready,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_head_valid,
    output logic             o_wr_en,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [CNT_W-1:0] o_count
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_wr_en;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // A full queue still accepts when ID drains the head in the same cycle.
    assign o_in_ready = !i_flush && (!w_full || i_out_ready);

    assign w_bypass = BYPASS && w_empty && i_in_valid && !i_flush;
    assign w_push   = i_in_valid && o_in_ready;
    assign w_pop    = !w_empty && i_out_ready && !i_flush;
    assign w_wr_en  = w_push && !(w_bypass && i_out_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            unique case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_valid = !w_empty;
    assign o_out_valid  = !w_empty || w_bypass;
    assign o_wr_en      = w_wr_en;
    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_count      = r_count;

    a_count_bounded: assert property (@(posedge clock) disable iff (reset)
        r_count <= CNT_W'(DEPTH));

    a_ptr_count_consistent: assert property (@(posedge clock) disable iff (reset)
        PTR_W'(r_wr_ptr - r_rd_ptr) == PTR_W'(r_count));

endmodule

// File: rtl/fetch_queue.sv
// IF->ID decoupling queue holding {pc_4, instruction} entries; flush drops everything queued.
// Optional FETCH_QUEUE_BYPASS_EN lets an entry reach ID in the cycle it arrives at an empty queue.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_pc_4,
    input  logic [WIDTH-1:0]       in_instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_pc_4,
    output logic [WIDTH-1:0]       out_instruction,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = ptr_width(DEPTH);

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic             w_head_valid;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;

    fetch_entry_t r_mem [DEPTH];
    fetch_entry_t w_in_entry;
    fetch_entry_t w_out_entry;

    fifo_ctrl #(
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS_EN)
    ) u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .i_flush      (flush),
        .i_in_valid   (in_valid),
        .i_out_ready  (out_ready),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_head_valid (w_head_valid),
        .o_wr_en      (w_wr_en),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_count      (count)
    );

    assign w_in_entry = '{pc_4: XLEN'(in_pc_4), instruction: XLEN'(in_instruction)};

    // NOTE: payload storage has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= w_in_entry;
        end
    end

    // NOTE: defaulting the output first keeps this block purely combinational.
    always_comb begin
        w_out_entry = '0;
        if (w_head_valid) begin
            w_out_entry = r_mem[w_rd_ptr];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (out_valid) begin
            w_out_entry = w_in_entry;
        end
`endif
    end

    assign out_pc_4        = WIDTH'(w_out_entry.pc_4);
    assign out_instruction = WIDTH'(w_out_entry.instruction);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus enqueues expected entries, a negedge
// monitor compares every ID-side transfer; directed checks cover occupancy and flow control.
module tb_fetch_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc_4;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_4;
    logic [31:0] in_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_4;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic t3_rdy [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc_4         (in_pc_4),
        .in_instruction  (in_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc_4        (out_pc_4),
        .out_instruction (out_instruction),
        .count           (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic acc);
        in_valid       = v;
        in_pc_4        = pc;
        in_instruction = instr;
        out_ready      = rdy;
        if (v && acc) sb.push_back('{pc_4: pc, instr: instr});
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every accepted head transfer must match the oldest expected entry.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop: got 0x%08h, expected no entry", out_instruction);
            end else begin
                e = sb.pop_front();
                check("pop_instruction", out_instruction, e.instr);
                check("pop_pc_4", out_pc_4, e.pc_4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0);
        nxt();
        nxt();
        reset = 1'b0;
        mid();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc_4", out_pc_4, 0);
        check("rst_out_instruction", out_instruction, 0);
        nxt();

        // Two back-to-back entries with ID always ready.
        drive(1, 32'h4, 32'h20014000, 1, 1);
        mid();
        check("t1_c0_out_valid", out_valid, BYP);
        nxt();
        drive(1, 32'h8, 32'h20014001, 1, 1);
        mid();
        check("t1_c1_out_instruction", out_instruction, BYP ? 32'h20014001 : 32'h20014000);
        nxt();
        drive(0, 0, 0, 1, 0);
        mid();
        check("t1_c2_count", count, BYP ? 0 : 1);
        nxt();
        drive(0, 0, 0, 0, 0);
        mid();
        check("t1_drained_count", count, 0);
        nxt();

        // Fill to DEPTH with ID stalled, then a fifth entry only with a same-cycle pop.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'h100 + 4 * i, 32'h31000000 + i, 0, 1);
            mid();
            check("t2_fill_in_ready", in_ready, 1);
            nxt();
        end
        drive(1, 32'h114, 32'h31000005, 0, 0);
        mid();
        check("t2_full_count", count, 4);
        check("t2_full_in_ready", in_ready, 0);
        nxt();
        drive(1, 32'h114, 32'h31000005, 1, 1);
        mid();
        check("t2_full_pop_in_ready", in_ready, 1);
        check("t2_full_pop_count", count, 4);
        nxt();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            mid();
            nxt();
        end
        drive(0, 0, 0, 0, 0);
        mid();
        check("t2_drained_count", count, 0);
        check("t2_drained_out_valid", out_valid, 0);
        nxt();

        // Six entries with interleaved pops; pointers wrap past DEPTH-1.
        for (int i = 1; i <= 6; i++) begin
            drive(1, 32'h200 + 4 * i, i, t3_rdy[i-1], 1);
            mid();
            nxt();
        end
        drive(0, 0, 0, 1, 0);
        mid();
        check("t3_count_after_pushes", count, 3);
        nxt();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 0);
            mid();
            nxt();
        end
        drive(0, 0, 0, 0, 0);
        mid();
        check("t3_drained_count", count, 0);
        nxt();

        // Flush with three queued and a new entry offered in the flush cycle.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 32'h300 + 4 * i, 32'h44000000 + i, 0, 1);
            mid();
            nxt();
        end
        flush = 1'b1;
        drive(1, 32'h3F0, 32'h44000099, 1, 0);
        sb.delete();
        mid();
        check("t4_flush_count_before", count, 3);
        check("t4_flush_in_ready", in_ready, 0);
        nxt();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0);
        mid();
        check("t4_after_flush_count", count, 0);
        check("t4_after_flush_out_valid", out_valid, 0);
        nxt();
        drive(1, 32'h310, 32'h44000010, 1, 1);
        mid();
        nxt();
        drive(0, 0, 0, 1, 0);
        mid();
        nxt();

        // Reset mid-stream with two queued and a simultaneous push/pop.
        for (int i = 1; i <= 2; i++) begin
            drive(1, 32'h400 + 4 * i, 32'h55000000 + i, 0, 1);
            mid();
            nxt();
        end
        reset = 1'b1;
        drive(1, 32'h4F0, 32'h55000003, 1, 0);
        sb.delete();
        mid();
        nxt();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        mid();
        check("t5_count", count, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_out_pc_4", out_pc_4, 0);
        check("t5_out_instruction", out_instruction, 0);
        nxt();

        // Head held stable while ID stalls for five cycles.
        drive(1, 32'h100, 32'h8C020000, 0, 1);
        mid();
        nxt();
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, 32'h104, 32'h8C020001, 0, k == 0);
            mid();
            check("t6_hold_valid", out_valid, 1);
            check("t6_hold_instruction", out_instruction, 32'h8C020000);
            check("t6_hold_pc_4", out_pc_4, 32'h100);
            nxt();
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            drive(0, 0, 0, 1, 0);
            mid();
            nxt();
        end
        check("sb_drained", sb.size(), 0);
        drive(0, 0, 0, 0, 0);
        mid();
        check("final_count", count, 0);
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
